// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: single-outstanding req/ack bus access, load formatting, stall.
// Optional MEM_ALIGN_CHECK_EN adds mem_addr_err and suppresses misaligned word accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_addr,
  input  logic [31:0] result_in,
  output logic [31:0] result_out,
  output logic        mem_stall,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        mem_addr_err
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic [3:0]           we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           off_q, off_d;
  logic                 rd_q, rd_d;
  logic                 sign_q, sign_d;
  logic                 byte_q, byte_d;
  logic [31:0]          load_q, load_d;
  logic                 err_q, err_d;
  logic                 addr_err_q, addr_err_d;

  logic        access, is_byte, misalign;
  logic [3:0]  we_enc;
  logic [31:0] wdata_enc;
  logic [7:0]  rbyte;
  logic [31:0] load_fmt;

  always_comb begin
    access    = mem_read_flag | mem_write_flag;
    // Any mask other than 0001 (including 0000) is a word access.
    is_byte   = (mem_sel == 4'b0001);
    we_enc    = 4'b0000;
    if (mem_write_flag) we_enc = is_byte ? (4'b0001 << mem_addr[1:0]) : 4'b1111;
    wdata_enc = is_byte ? {4{mem_write_data[7:0]}} : mem_write_data;
`ifdef MEM_ALIGN_CHECK_EN
    misalign  = access && !is_byte && (mem_addr[1:0] != 2'b00);
`else
    misalign  = 1'b0;
`endif
  end

  always_comb begin
    unique case (off_q)
      2'd0:    rbyte = bus_rdata[7:0];
      2'd1:    rbyte = bus_rdata[15:8];
      2'd2:    rbyte = bus_rdata[23:16];
      default: rbyte = bus_rdata[31:24];
    endcase
    load_fmt = byte_q ? {{24{sign_q & rbyte[7]}}, rbyte} : bus_rdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    rd_d       = rd_q;
    sign_d     = sign_q;
    byte_d     = byte_q;
    load_d     = load_q;
    err_d      = 1'b0;
    addr_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          rd_d   = mem_read_flag & ~mem_write_flag;
          sign_d = mem_sign_ext_flag;
          byte_d = is_byte;
          off_d  = mem_addr[1:0];
          if (misalign) begin
            addr_err_d = 1'b1;
            state_d    = StDone;
          end else begin
            req_d   = 1'b1;
            we_d    = we_enc;
            addr_d  = {mem_addr[31:2], 2'b00};
            wdata_d = wdata_enc;
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus_ack || (cnt_q == CNT_WIDTH'(TIMEOUT - 1))) begin
          req_d   = 1'b0;
          we_d    = 4'b0000;
          addr_d  = '0;
          wdata_d = '0;
          state_d = StDone;
          if (bus_ack) begin
            load_d = load_fmt;
          end else begin
            load_d = '0;
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= '0;
      off_q      <= 2'b00;
      rd_q       <= 1'b0;
      sign_q     <= 1'b0;
      byte_q     <= 1'b0;
      load_q     <= '0;
      err_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      sign_q     <= sign_d;
      byte_q     <= byte_d;
      load_q     <= load_d;
      err_q      <= err_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    mem_stall  = ((state_q == StIdle) && access) || (state_q == StWait);
    result_out = ((state_q == StDone) && rd_q && !addr_err_q) ? load_q : result_in;
    bus_req    = req_q;
    bus_we     = we_q;
    bus_addr   = addr_q;
    bus_wdata  = wdata_q;
    bus_err    = err_q;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_addr_err = addr_err_q;
`endif

endmodule
